weight_loader_mc: RTL and testbench

Parametrised multi-channel weight loader: streams `load_len` words from NUM_CH parallel weight BRAM banks. A single shared read address is issued per word. Each bank's lane is presented on a valid/ready output with full backpressure support. It sits between the weight BRAMs (native port, 1-cycle read latency) and the PE array weight inputs. It is the generalised successor of the fixed 4-bank, free-running weight loader: channel count, widths, address step, transfer length, backpressure, abort and a completion pulse are added.

---
 rtl/weight_loader_pkg.sv | 19 +
 rtl/weight_loader_mc_if.sv | 14 +
 rtl/weight_skid_buf.sv | 50 +++++
 rtl/weight_loader_mc.sv | 159 +++++++++++++++
 tb/tb_weight_loader_mc.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_loader_pkg.sv
// Shared definitions for the multi-channel weight loader: FSM encoding,
// BRAM read latency and the occupancy rule that gates read issue.
package weight_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int BRAM_RD_LATENCY = 1;
    localparam int BUF_DEPTH       = 2;

    // occ counts buffered plus in-flight words; a same-cycle pop frees a slot.
    function automatic logic can_issue(input int occ, input logic pop);
        return (occ - int'(pop)) < BUF_DEPTH;
    endfunction

endpackage

// File: rtl/weight_loader_mc_if.sv
// Weight output stream from the loader to the PE array.
// A word transfers on every clock edge where weight_vld && weight_rdy; while
// weight_vld is high and weight_rdy low, weight is held stable by the master.
interface weight_loader_mc_if #(
    parameter int NUM_CH       = 4,
    parameter int WEIGHT_WIDTH = 8
);
    logic [NUM_CH*WEIGHT_WIDTH-1:0] weight;
    logic                           weight_vld;
    logic                           weight_rdy;

    modport master (output weight, output weight_vld, input weight_rdy);
    modport slave  (input weight, input weight_vld, output weight_rdy);
endinterface

// File: rtl/weight_skid_buf.sv
// Two-entry FIFO holding captured weight words; the head drives the output
// stream. Flush drops contents without touching storage.
module weight_skid_buf
    import weight_loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [BUF_DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/weight_loader_mc.sv
// Streams load_len words from NUM_CH weight BRAM banks through a shared
// address, presenting each word on a valid/ready stream with backpressure.
module weight_loader_mc
    import weight_loader_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int BRAM_ADDR_BIT = 32,
    parameter int BRAM_WIDTH    = 32,
    parameter int WEIGHT_WIDTH  = 8,
    parameter int ADDR_STEP     = 4,
    parameter int LEN_BIT       = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_start,
    input  logic                           load_abort,
    input  logic [BRAM_ADDR_BIT-1:0]       base_addr,
    input  logic [LEN_BIT-1:0]             load_len,
    output logic                           busy,
    output logic                           load_done,
    weight_loader_mc_if.master             w_if,
    output logic                           BRAM_clk,
    output logic                           BRAM_en,
    output logic                           BRAM_rst,
    output logic [BRAM_WIDTH-1:0]          BRAM_din,
    output logic [BRAM_ADDR_BIT/8-1:0]     BRAM_wen,
    output logic [BRAM_ADDR_BIT-1:0]       BRAM_addr,
    input  logic [NUM_CH*BRAM_WIDTH-1:0]   BRAM_dout,
    output state_t                         o_dbg_state
);

    localparam int DW = NUM_CH * WEIGHT_WIDTH;

    state_t                     r_state;
    state_t                     w_next_state;
    logic [BRAM_ADDR_BIT-1:0]   r_addr;
    logic [LEN_BIT-1:0]         r_issue_left;
    logic [LEN_BIT-1:0]         r_pop_left;
    logic [BRAM_RD_LATENCY-1:0] r_inflight;
    logic                       r_done;

    logic [1:0]                 w_count;
    logic [DW-1:0]              w_head;
    logic [DW-1:0]              w_lanes;
    logic                       w_vld;
    logic                       w_pop;
    logic                       w_abort;
    logic                       w_start;
    logic                       w_issue;
    logic                       w_final_pop;
    logic                       w_push;
    int                         w_occ;
    logic                       w_unused_dout;

    // Each lane takes the low WEIGHT_WIDTH bits of its bank.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
        assign w_lanes[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
            BRAM_dout[gi*BRAM_WIDTH +: WEIGHT_WIDTH];
    end
    assign w_unused_dout = ^BRAM_dout;

    assign w_vld   = (w_count != 2'd0);
    assign w_pop   = w_vld & w_if.weight_rdy;
    assign w_abort = load_abort & (r_state != ST_IDLE);
    assign w_start = load_start & (r_state == ST_IDLE);
    assign w_occ   = int'(w_count) + $countones(r_inflight);
    assign w_push  = r_inflight[BRAM_RD_LATENCY-1] & ~w_abort;

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_final_pop  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_start && (load_len != '0)) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_abort) begin
                    w_next_state = ST_IDLE;
                end else if (can_issue(w_occ, w_pop)) begin
                    w_issue = 1'b1;
                    if (r_issue_left == LEN_BIT'(1)) begin
                        w_next_state = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_pop && (r_pop_left == LEN_BIT'(1))) begin
                    w_final_pop  = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_issue_left <= '0;
            r_pop_left   <= '0;
            r_inflight   <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_final_pop | (w_start & (load_len == '0));
            // Abort discards the read still in flight; its data is never pushed.
            if (w_abort) begin
                r_inflight <= '0;
            end else begin
                r_inflight <= (r_inflight << 1) | BRAM_RD_LATENCY'(w_issue);
            end
            if (w_start) begin
                r_addr       <= base_addr;
                r_issue_left <= load_len;
                r_pop_left   <= load_len;
            end else begin
                if (w_issue) begin
                    r_addr       <= r_addr + BRAM_ADDR_BIT'(ADDR_STEP);
                    r_issue_left <= r_issue_left - LEN_BIT'(1);
                end
                if (w_pop) begin
                    r_pop_left <= r_pop_left - LEN_BIT'(1);
                end
            end
        end
    end

    weight_skid_buf #(
        .WIDTH (DW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_abort),
        .i_push  (w_push),
        .i_din   (w_lanes),
        .i_pop   (w_pop & ~w_abort),
        .o_dout  (w_head),
        .o_count (w_count)
    );

    assign busy            = (r_state != ST_IDLE);
    assign load_done       = r_done;
    assign w_if.weight     = w_head;
    assign w_if.weight_vld = w_vld;
    assign BRAM_clk        = clk;
    assign BRAM_en         = w_issue;
    assign BRAM_rst        = 1'b0;
    assign BRAM_din        = '0;
    assign BRAM_wen        = '0;
    assign BRAM_addr       = r_addr;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_weight_loader_mc.sv
// Bench for weight_loader_mc: randomized loads against a word-level reference
// model, with an expected-word queue popped by a monitor on every handshake.
module tb_weight_loader_mc;
    import weight_loader_pkg::*;

    localparam int NUM_CH = 4;
    localparam int BW     = 32;
    localparam int WW     = 8;
    localparam int AB     = 32;
    localparam int LB     = 16;
    localparam int STEP   = 4;
    localparam int DW     = NUM_CH * WW;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic                   load_start;
    logic                   load_abort;
    logic [AB-1:0]          base_addr;
    logic [LB-1:0]          load_len;
    logic                   busy;
    logic                   load_done;
    logic                   BRAM_clk;
    logic                   BRAM_en;
    logic                   BRAM_rst;
    logic [BW-1:0]          BRAM_din;
    logic [AB/8-1:0]        BRAM_wen;
    logic [AB-1:0]          BRAM_addr;
    logic [NUM_CH*BW-1:0]   BRAM_dout;
    state_t                 dbg_state;

    weight_loader_mc_if #(.NUM_CH(NUM_CH), .WEIGHT_WIDTH(WW)) w_if ();

    weight_loader_mc #(
        .NUM_CH(NUM_CH), .BRAM_ADDR_BIT(AB), .BRAM_WIDTH(BW),
        .WEIGHT_WIDTH(WW), .ADDR_STEP(STEP), .LEN_BIT(LB)
    ) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_abort(load_abort),
        .base_addr(base_addr), .load_len(load_len), .busy(busy),
        .load_done(load_done), .w_if(w_if), .BRAM_clk(BRAM_clk),
        .BRAM_en(BRAM_en), .BRAM_rst(BRAM_rst), .BRAM_din(BRAM_din),
        .BRAM_wen(BRAM_wen), .BRAM_addr(BRAM_addr), .BRAM_dout(BRAM_dout),
        .o_dbg_state(dbg_state)
    );

    // bank contents: a fixed function of lane and byte address
    function automatic logic [BW-1:0] bank_word(input int lane, input logic [AB-1:0] a);
        logic [7:0] lo;
        lo = a[9:2] ^ a[31:24] ^ 8'(lane * 37 + 11);
        return {a[23:0] ^ 24'h5A3C96, lo};
    endfunction

    function automatic logic [DW-1:0] exp_word(input logic [AB-1:0] a);
        logic [DW-1:0] w;
        logic [BW-1:0] d;
        for (int i = 0; i < NUM_CH; i++) begin
            d = bank_word(i, a);
            w[i*WW +: WW] = d[WW-1:0];
        end
        return w;
    endfunction

    always @(posedge clk) begin
        if (BRAM_en === 1'b1) begin
            for (int i = 0; i < NUM_CH; i++) begin
                BRAM_dout[i*BW +: BW] <= bank_word(i, BRAM_addr);
            end
        end
    end

    // scoreboard and reference-model state
    logic [DW-1:0] exp_q[$];
    logic [AB-1:0] addr_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    bit  model_busy = 1'b0;
    bit  pend_done = 1'b0;
    bit  exp_reset = 1'b0;
    bit  exp_abort = 1'b0;
    bit  first_en_due = 1'b0;
    int  vld_due = -1;
    int  issued = 0;
    int  popped = 0;
    int  pop_left = 0;
    bit  prev_hold = 1'b0;
    logic [DW-1:0] prev_weight = '0;
    int  rdy_mode = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        exp_q.delete();
        addr_q.delete();
        model_busy   = 1'b0;
        issued       = 0;
        popped       = 0;
        pop_left     = 0;
        first_en_due = 1'b0;
        vld_due      = -1;
        prev_hold    = 1'b0;
    endfunction

    // monitor: one pass of the reference model per cycle
    always @(negedge clk) begin
        bit pop_now;
        bit final_pop;
        bit done_next;
        bit abort_now;
        if (mon_en) begin
            pop_now   = (w_if.weight_vld === 1'b1) && (w_if.weight_rdy === 1'b1);
            abort_now = load_abort && model_busy;
            final_pop = 1'b0;
            done_next = 1'b0;
            if (exp_reset) begin
                check("rst_weight", 64'(w_if.weight), 64'(0));
                check("rst_vld", 64'(w_if.weight_vld), 64'(0));
                check("rst_en", 64'(BRAM_en), 64'(0));
                check("rst_addr", 64'(BRAM_addr), 64'(0));
                check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
                exp_reset = 1'b0;
            end
            if (exp_abort) begin
                check("abort_vld", 64'(w_if.weight_vld), 64'(0));
                exp_abort = 1'b0;
            end
            check("busy", 64'(busy), 64'(model_busy));
            check("load_done", 64'(load_done), 64'(pend_done));
            if (rst) begin
                if (first_en_due && !load_abort) begin
                    check("first_en", 64'(BRAM_en), 64'(1));
                end
                first_en_due = 1'b0;
                if (vld_due == 0) check("first_vld", 64'(w_if.weight_vld), 64'(1));
                if (vld_due >= 0) vld_due--;
                if (prev_hold) begin
                    check("hold_vld", 64'(w_if.weight_vld), 64'(1));
                    check("hold_data", 64'(w_if.weight), 64'(prev_weight));
                end
                if (abort_now) check("en_in_abort", 64'(BRAM_en), 64'(0));
                if (BRAM_en === 1'b1) begin
                    check("en_expected", 64'(addr_q.size() != 0), 64'(1));
                    if (addr_q.size() != 0) check("bram_addr", 64'(BRAM_addr), 64'(addr_q.pop_front()));
                    check("occ_limit", 64'((issued - popped - int'(pop_now)) < 2), 64'(1));
                    issued++;
                end
                if (pop_now) begin
                    check("word_expected", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) check("weight", 64'(w_if.weight), 64'(exp_q.pop_front()));
                    popped++;
                    pop_left--;
                    final_pop = model_busy && (pop_left == 0);
                end
            end
            prev_hold   = rst && !abort_now && (w_if.weight_vld === 1'b1) && (w_if.weight_rdy !== 1'b1);
            prev_weight = w_if.weight;
            if (!rst) begin
                model_clear();
                exp_reset = 1'b1;
            end else if (abort_now) begin
                model_clear();
                exp_abort = 1'b1;
            end else if (final_pop) begin
                model_busy = 1'b0;
                done_next  = 1'b1;
            end else if (load_start && !model_busy) begin
                if (load_len == '0) begin
                    done_next = 1'b1;
                end else begin
                    model_busy   = 1'b1;
                    issued       = 0;
                    popped       = 0;
                    pop_left     = int'(load_len);
                    first_en_due = 1'b1;
                    vld_due      = 2;
                    for (int k = 0; k < int'(load_len); k++) begin
                        addr_q.push_back(base_addr + AB'(k * STEP));
                        exp_q.push_back(exp_word(base_addr + AB'(k * STEP)));
                    end
                end
            end
            pend_done = done_next;
        end
    end

    // consumer ready: 0 low, 1 high, otherwise random per cycle
    initial begin
        w_if.weight_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       w_if.weight_rdy = 1'b0;
                1:       w_if.weight_rdy = 1'b1;
                default: w_if.weight_rdy = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (model_busy && n < budget) begin
            tick(1);
            n++;
        end
        check("wait_idle_timeout", 64'(model_busy), 64'(0));
    endtask

    task automatic wait_popped(input int target, input int budget);
        int n = 0;
        while (popped < target && n < budget) begin
            tick(1);
            n++;
        end
        check("wait_popped_timeout", 64'(popped >= target), 64'(1));
    endtask

    task automatic start_load(input logic [AB-1:0] b, input logic [LB-1:0] l);
        base_addr  = b;
        load_len   = l;
        load_start = 1'b1;
        tick(1);
        load_start = 1'b0;
    endtask

    task automatic pulse_abort();
        load_abort = 1'b1;
        tick(1);
        load_abort = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        load_start = 1'b0;
        load_abort = 1'b0;
        base_addr = '0;
        load_len = '0;
        tick(3);
        exp_reset = 1'b1;
        mon_en = 1'b1;
        rst = 1'b1;
        tick(2);

        // nominal burst, then same burst under random backpressure
        rdy_mode = 1;
        start_load(32'h100, 16'd8);
        wait_idle(200);
        rdy_mode = 2;
        start_load(32'h100, 16'd8);
        wait_idle(400);

        // zero length, then abort while idle
        rdy_mode = 1;
        start_load(32'h300, 16'd0);
        tick(3);
        pulse_abort();
        tick(2);

        // abort after three words, then a short reload from 0
        start_load(32'h40, 16'd8);
        wait_popped(3, 50);
        pulse_abort();
        wait_idle(50);
        start_load(32'h0, 16'd2);
        wait_idle(50);

        // reset in DRAIN with a full buffer; start held during reset
        rdy_mode = 0;
        start_load(32'h200, 16'd2);
        tick(6);
        rst = 1'b0;
        load_start = 1'b1;
        base_addr = 32'h500;
        load_len = 16'd5;
        tick(2);
        rst = 1'b1;
        load_start = 1'b0;
        rdy_mode = 1;
        tick(3);

        // address wrap
        start_load(32'hFFFF_FFF8, 16'd4);
        wait_idle(50);

        // random loads, ignored restarts and occasional aborts
        for (int t = 0; t < 10; t++) begin
            rdy_mode = ($urandom_range(0, 3) == 0) ? 1 : 2;
            start_load($urandom & 32'hFFFF_FFFC, LB'($urandom_range(1, 12)));
            tick(2);
            if (model_busy) begin
                base_addr  = $urandom;
                load_len   = LB'($urandom_range(1, 12));
                load_start = 1'b1;
                tick(1);
                load_start = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) begin
                tick($urandom_range(1, 8));
                if (model_busy) pulse_abort();
            end
            wait_idle(400);
        end

        tick(4);
        check("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
